// File: rtl/perceptron_trainer.sv
// Training stage for a 2-input perceptron: feeds x/weights, samples p_in, applies the learning rule.
// Optional WEIGHT_SAT_EN: weight fields saturate instead of wrapping.
module perceptron_trainer #(
  parameter int unsigned EPOCH_LEN   = 4,
  parameter int unsigned MAX_EPOCHS  = 15,
  parameter logic [12:0] INIT_WEIGHT = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [1:0]  sample_x,
  input  logic        sample_target,
  input  logic        p_in,
  output logic [1:0]  x_out,
  output logic [12:0] weight_out,
  output logic        upd_valid,
  output logic        upd_err,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic [3:0]  epoch_cnt
);

  localparam logic [3:0] EPOCH_LEN_C  = 4'(EPOCH_LEN);
  localparam logic [3:0] MAX_EPOCHS_C = 4'(MAX_EPOCHS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_UPDATE, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  x_q;
  logic        target_q;
  logic [12:0] weight_q;
  logic [12:0] weight_d;
  logic        ready_q;
  logic        upd_valid_q;
  logic        upd_err_q;
  logic        busy_q;
  logic        done_q;
  logic        conv_q;
  logic [3:0]  epoch_q;
  logic [3:0]  samp_q;
  logic [3:0]  errc_q;

  logic        err;
  logic        mis_pos;
  logic        mis_neg;
  logic [3:0]  samp_d;
  logic [3:0]  errc_d;
  logic [3:0]  epoch_d;

  // 5-bit two's complement weight adjusted by +1/-1/0
  function automatic logic [4:0] adj_w(input logic [4:0] w, input logic inc, input logic dec);
    logic [4:0] r;
`ifdef WEIGHT_SAT_EN
    logic signed [5:0] s;
    s = $signed({w[4], w}) + $signed({5'd0, inc}) - $signed({5'd0, dec});
    if (s > 6'sd15)       r = 5'h0F;
    else if (s < -6'sd16) r = 5'h10;
    else                  r = s[4:0];
`else
    r = w + {4'd0, inc} - {4'd0, dec};
`endif
    return r;
  endfunction

  // 3-bit unsigned threshold adjusted by +1/-1/0
  function automatic logic [2:0] adj_th(input logic [2:0] th, input logic inc, input logic dec);
    logic [2:0] r;
`ifdef WEIGHT_SAT_EN
    logic [3:0] s;
    s = {1'b0, th} + {3'd0, inc} - {3'd0, dec};
    if (s[3]) r = dec ? 3'd0 : 3'd7;
    else      r = s[2:0];
`else
    r = th + {2'd0, inc} - {2'd0, dec};
`endif
    return r;
  endfunction

  always_comb begin
    err      = p_in ^ target_q;
    mis_pos  = target_q & ~p_in;
    mis_neg  = ~target_q & p_in;
    samp_d   = samp_q + 4'd1;
    errc_d   = errc_q + {3'd0, err};
    epoch_d  = epoch_q + 4'd1;
    weight_d = {adj_th(weight_q[12:10], mis_neg, mis_pos),
                adj_w(weight_q[9:5], mis_pos & x_q[1], mis_neg & x_q[1]),
                adj_w(weight_q[4:0], mis_pos & x_q[0], mis_neg & x_q[0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= 2'b00;
      target_q    <= 1'b0;
      weight_q    <= INIT_WEIGHT;
      ready_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conv_q      <= 1'b0;
      epoch_q     <= 4'd0;
      samp_q      <= 4'd0;
      errc_q      <= 4'd0;
    end else begin
      upd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            samp_q  <= 4'd0;
            errc_q  <= 4'd0;
            epoch_q <= 4'd0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (sample_valid && ready_q) begin
            x_q      <= sample_x;
            target_q <= sample_target;
            ready_q  <= 1'b0;
            state_q  <= S_EVAL;
          end
        end
        S_EVAL: state_q <= S_UPDATE;
        S_UPDATE: begin
          weight_q    <= weight_d;
          upd_valid_q <= 1'b1;
          upd_err_q   <= err;
          errc_q      <= errc_d;
          if (samp_d == EPOCH_LEN_C) begin
            samp_q  <= 4'd0;
            epoch_q <= epoch_d;
            if (errc_d == 4'd0 || epoch_d == MAX_EPOCHS_C) begin
              conv_q  <= (errc_d == 4'd0);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              errc_q  <= 4'd0;
              ready_q <= 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            samp_q  <= samp_d;
            ready_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign x_out        = x_q;
  assign weight_out   = weight_q;
  assign upd_valid    = upd_valid_q;
  assign upd_err      = upd_err_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign epoch_cnt    = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer; expected updates go through a scoreboard queue.
// Two instances share stimulus: one with zero initial weights, one preloaded with W1=15.
module tb_perceptron_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [1:0]  sample_x = 2'b00;
  logic        sample_target = 1'b0;
  logic        p_stub = 1'b0;

  logic        sample_ready, upd_valid, upd_err, busy, done, converged;
  logic [1:0]  x_out;
  logic [12:0] weight_out;
  logic [3:0]  epoch_cnt;

  logic        b_sample_ready, b_upd_valid, b_upd_err, b_busy, b_done, b_converged;
  logic [1:0]  b_x_out;
  logic [12:0] b_weight;
  logic [3:0]  b_epoch_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic        err;
    logic [12:0] w;
    logic [12:0] w5;
  } exp_t;
  exp_t sb[$];

  logic [12:0] w_model;
  logic [12:0] w5_model;

`ifdef WEIGHT_SAT_EN
  localparam logic [12:0] T2_W  = 13'h0021;
  localparam logic [4:0]  T5_W1 = 5'h0F;
`else
  localparam logic [12:0] T2_W  = 13'h1C21;
  localparam logic [4:0]  T5_W1 = 5'h10;
`endif
  localparam logic [12:0] T4_W = 13'h0108;

  always #5 clk = ~clk;

  perceptron_trainer #(.EPOCH_LEN(4), .MAX_EPOCHS(2), .INIT_WEIGHT(13'h0000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_x(sample_x), .sample_target(sample_target),
    .p_in(p_stub), .x_out(x_out), .weight_out(weight_out), .upd_valid(upd_valid),
    .upd_err(upd_err), .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt)
  );

  perceptron_trainer #(.EPOCH_LEN(4), .MAX_EPOCHS(2), .INIT_WEIGHT(13'h000F)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_ready(b_sample_ready), .sample_x(sample_x), .sample_target(sample_target),
    .p_in(p_stub), .x_out(b_x_out), .weight_out(b_weight), .upd_valid(b_upd_valid),
    .upd_err(b_upd_err), .busy(b_busy), .done(b_done), .converged(b_converged),
    .epoch_cnt(b_epoch_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference learning rule on plain integers.
  function automatic logic [12:0] model_w(input logic [12:0] w, input logic [1:0] x,
                                          input logic t, input logic p);
    int w1, w2, th, d;
    logic [4:0] f1, f2;
    logic [2:0] ft;
    f1 = w[4:0];
    f2 = w[9:5];
    w1 = $signed(f1);
    w2 = $signed(f2);
    th = int'(w[12:10]);
    d  = (t && !p) ? 1 : ((!t && p) ? -1 : 0);
    if (x[0]) w1 += d;
    if (x[1]) w2 += d;
    th -= d;
`ifdef WEIGHT_SAT_EN
    w1 = (w1 > 15) ? 15 : ((w1 < -16) ? -16 : w1);
    w2 = (w2 > 15) ? 15 : ((w2 < -16) ? -16 : w2);
    th = (th > 7) ? 7 : ((th < 0) ? 0 : th);
`endif
    f1 = w1[4:0];
    f2 = w2[4:0];
    ft = th[2:0];
    return {ft, f2, f1};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    w_model  = 13'h0000;
    w5_model = 13'h000F;
    sb.delete();
    chk("rst_weight", weight_out, 13'h0000);
    chk("rst_weight5", b_weight, 13'h000F);
    chk("rst_ready", sample_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_epoch", epoch_cnt, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_xout", x_out, 2'b00);
    chk("rst_conv", converged, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", sample_ready, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [1:0] x, input logic t, input logic p);
    exp_t e;
    logic [12:0] w_prev;
    int n;
    p_stub = p;
    sample_x = x;
    sample_target = t;
    sample_valid = 1'b1;
    n = 0;
    while (sample_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", sample_ready, 1'b1);
    if (sample_ready !== 1'b1) begin
      sample_valid = 1'b0;
      return;
    end
    w_prev   = w_model;
    w_model  = model_w(w_model, x, t, p);
    w5_model = model_w(w5_model, x, t, p);
    e.err = (p != t);
    e.w   = w_model;
    e.w5  = w5_model;
    sb.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("x_latch", x_out, x);
    chk("uv_eval", upd_valid, 1'b0);
    chk("ready_eval", sample_ready, 1'b0);
    @(negedge clk);
    chk("uv_update", upd_valid, 1'b0);
    chk("w_hold", weight_out, w_prev);
    @(negedge clk);
    chk("uv_lat2", upd_valid, 1'b1);
    n = 0;
    while (upd_valid !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (upd_valid === 1'b1) begin
        chk("upd_err", upd_err, e.err);
        chk("weight", weight_out, e.w);
        chk("weight5", b_weight, e.w5);
      end
    end
    $display("sample x=%b t=%b p=%b -> upd_valid=%b err=%b w=%h w5=%h epoch=%0d done=%b conv=%b",
             x, t, p, upd_valid, upd_err, weight_out, b_weight, epoch_cnt, done, converged);
    @(negedge clk);
    chk("uv_pulse", upd_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and start handshake
    do_reset();
    pulse_start();
    chk("start_ready", sample_ready, 1'b1);
    chk("start_busy", busy, 1'b1);

    // Single misclassified sample, target 1
    send_sample(2'b11, 1'b1, 1'b0);
    chk("t2_const", weight_out, T2_W);
    chk("t2_done", done, 1'b0);

    // One clean epoch converges
    do_reset();
    pulse_start();
    send_sample(2'b00, 1'b0, 1'b0);
    send_sample(2'b01, 1'b1, 1'b1);
    send_sample(2'b10, 1'b1, 1'b1);
    chk("t3_notdone", done, 1'b0);
    send_sample(2'b11, 1'b0, 1'b0);
    chk("t3_done", done, 1'b1);
    chk("t3_conv", converged, 1'b1);
    chk("t3_epoch", epoch_cnt, 4'd1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_weight", weight_out, 13'h0000);

    // Restart from DONE; always wrong until MAX_EPOCHS
    pulse_start();
    chk("t4_done_clr", done, 1'b0);
    chk("t4_conv_clr", converged, 1'b0);
    chk("t4_epoch_clr", epoch_cnt, 4'd0);
    chk("t4_ready", sample_ready, 1'b1);
    for (int i = 0; i < 4; i++) send_sample(2'b11, 1'b1, 1'b0);
    chk("t4_ep1", epoch_cnt, 4'd1);
    chk("t4_ep1_done", done, 1'b0);
    pulse_start();
    chk("t4_start_ign", epoch_cnt, 4'd1);
    chk("t4_start_rdy", sample_ready, 1'b1);
    for (int i = 0; i < 4; i++) send_sample(2'b11, 1'b1, 1'b0);
    chk("t4_done", done, 1'b1);
    chk("t4_conv", converged, 1'b0);
    chk("t4_epoch", epoch_cnt, 4'd2);
    chk("t4_const", weight_out, T4_W);

    // W1 at +15 incremented
    do_reset();
    pulse_start();
    send_sample(2'b01, 1'b1, 1'b0);
    chk("t5_w1", b_weight[4:0], T5_W1);

    // Reset during EVAL aborts the sample and restores weights
    sample_x = 2'b11;
    sample_target = 1'b1;
    p_stub = 1'b0;
    sample_valid = 1'b1;
    chk("t6_ready", sample_ready, 1'b1);
    @(negedge clk);
    chk("t6_in_eval", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w_model  = 13'h0000;
    w5_model = 13'h000F;
    chk("t6_weight", weight_out, 13'h0000);
    chk("t6_weight5", b_weight, 13'h000F);
    chk("t6_busy", busy, 1'b0);
    chk("t6_uv", upd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_hs", sample_ready, 1'b0);
      chk("t6_no_uv", upd_valid, 1'b0);
      chk("t6_xout", x_out, 2'b00);
    end
    sample_valid = 1'b0;
    pulse_start();
    send_sample(2'b10, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
